alu_exec_unit: RTL
==================

// Module: alu_exec_unit
// PURPOSE
//  Execution side of the RS->FU dispatch interface: takes one ready ALU/branch op per cycle
//  from the reservation station, computes the result, branch decision and target, and
//  broadcasts {RobId, value} on the ALU result bus that RS, LSB and ROB snoop.
//  A result queue absorbs CDB back-pressure (cdb_ready low). fu_next_full throttles RS dispatch.
// PARAMETERS
//  QDEPTH      4   result-queue entries, power of 2, >= 4
//  MUL_STAGES  3   multiplier pipeline depth; used only with ALU_MUL_EN
// PORTS
//  clk            in   1         clock
//  rst            in   1         synchronous, active-high reset
//  rdy            in   1         global ready; low = freeze
//  flush          in   1         mispredict rollback; discard all in-flight work
//  in_valid       in   1         dispatch strobe (RS FU_enable)
//  in_op          in   OP_LOG    operation, `OP_* encoding from config.v
//  in_Vj, in_Vk   in   32        operand values
//  in_Imm         in   32        sign-extended immediate
//  in_DestRob     in   ROB_LOG   destination ROB tag
//  in_CurPC       in   32        instruction PC
//  cdb_ready      in   1         bus accepts head result this cycle
//  out_valid      out  1         head result valid
//  out_RobId      out  ROB_LOG   head tag
//  out_value      out  32        rd value
//  out_jump       out  1         control transfer taken
//  out_target     out  32        next PC for branch/jump
//  fu_next_full   out  1         RS must not dispatch next cycle
// BEHAVIOUR
//  - Reset: queue empty, count 0, out_valid 0, fu_next_full 0, multiplier stages invalid.
//  - Dispatch accepted when in_valid & rdy & ~flush; result is pushed at that edge.
//    out_* shows the head combinationally, so latency is 1 cycle when the queue is empty.
//  - Pop at an edge where out_valid & cdb_ready & rdy. Push and pop may occur together; count unchanged.
//  - Queue is a circular buffer; pointers wrap modulo QDEPTH. No bypass around the queue.
//  - fu_next_full = (count + inflight_mul) >= QDEPTH-2 (registered-path safe margin).
//    Push when full is a protocol error: the entry is dropped, state unchanged; sim-only $error.
//  - rdy low: no push, no pop, mul pipeline holds, out_valid forced 0, contents kept.
//  - flush (rdy high): the queue empties and mul stages invalidate at that edge.
//    in_valid in the same cycle is ignored and out_valid = 0 next cycle.
//    rst has priority over flush.
//  - Arithmetic (32-bit wraparound):
//    ADD/ADDI, SUB, AND/OR/XOR(+I), SLL/SRL/SRA(+I) use shamt [4:0], SLT(I) signed,
//    SLTU(I) unsigned, LUI = Imm, AUIPC = CurPC+Imm.
//    Non-control ops: out_jump = 0, out_target = CurPC+4.
//  - JAL: value = CurPC+4, jump = 1, target = CurPC+Imm.
//  - JALR: value = CurPC+4, jump = 1, target = (Vj+Imm) & ~1.
//  - BEQ/BNE/BLT/BGE/BLTU/BGEU: value = 0; jump = condition.
//    target = jump ? CurPC+Imm : CurPC+4.
//  - Unknown op: value 0, jump 0 (never hangs).
// CONFIGURATION
//  ALU_MUL_EN defined:
//   - MUL/MULH/MULHSU/MULHU go through a MUL_STAGES pipeline.
//     Its result is pushed MUL_STAGES cycles after dispatch.
//   - A same-edge collision with a 1-cycle ALU result pushes two entries, multiplier
//     (older) first; the queue has 2 write ports.
//   - inflight_mul counts valid mul stages.
//  ALU_MUL_EN undefined:
//   - No multiplier logic, inflight_mul = 0, single write port.
//   - M-ops are treated as unknown op.
// TESTING
//  1 ADD Vj=5 Vk=7 Rob=3, cdb_ready=1 -> next cycle out_valid=1, RobId=3, value=12, jump=0.
//  2 BLT Vj=-1 Vk=1 PC=0x100 Imm=0x20 -> jump=1, target=0x120.
//    Same with BLTU -> jump=0, target=0x104.
//  3 JALR Vj=0x1001 Imm=4 PC=0x40 -> value=0x44, target=0x1004.
//  4 cdb_ready=0, dispatch ADDs every cycle until fu_next_full=1 (count=QDEPTH-2).
//    Raise cdb_ready -> results drain in issue order, one per cycle.
//  5 Queue holds 3 entries, assert flush with in_valid=1 -> next cycle out_valid=0, count 0.
//    Next dispatch takes 1 cycle.
//  6 rdy=0 for 3 cycles with 2 entries queued -> out_valid=0, nothing lost.
//    [ALU_MUL_EN] MUL 6*7 at t0, ADD at t2 -> both pushed at t3 edge; MUL=42 broadcast first, then ADD.

Source files
------------

// File: rtl/alu_exec_unit.sv
// ALU/branch execution unit with result queue feeding the CDB.
// Optional multiplier pipeline is enabled by defining ALU_MUL_EN.
package alu_exec_pkg;
  localparam int OP_LOG = 6;
  localparam logic [OP_LOG-1:0]
    OP_ADD  = 6'd0,  OP_SUB   = 6'd1,  OP_AND   = 6'd2,  OP_OR    = 6'd3,
    OP_XOR  = 6'd4,  OP_SLL   = 6'd5,  OP_SRL   = 6'd6,  OP_SRA   = 6'd7,
    OP_SLT  = 6'd8,  OP_SLTU  = 6'd9,  OP_ADDI  = 6'd10, OP_ANDI  = 6'd11,
    OP_ORI  = 6'd12, OP_XORI  = 6'd13, OP_SLLI  = 6'd14, OP_SRLI  = 6'd15,
    OP_SRAI = 6'd16, OP_SLTI  = 6'd17, OP_SLTIU = 6'd18, OP_LUI   = 6'd19,
    OP_AUIPC = 6'd20, OP_JAL  = 6'd21, OP_JALR  = 6'd22, OP_BEQ   = 6'd23,
    OP_BNE  = 6'd24, OP_BLT   = 6'd25, OP_BGE   = 6'd26, OP_BLTU  = 6'd27,
    OP_BGEU = 6'd28, OP_MUL   = 6'd29, OP_MULH  = 6'd30, OP_MULHSU = 6'd31,
    OP_MULHU = 6'd32;
endpackage

module alu_exec_unit
  import alu_exec_pkg::*;
#(
  parameter int QDEPTH     = 4,
  parameter int MUL_STAGES = 3,
  parameter int ROB_LOG    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [OP_LOG-1:0]  in_op,
  input  logic [31:0]        in_Vj,
  input  logic [31:0]        in_Vk,
  input  logic [31:0]        in_Imm,
  input  logic [ROB_LOG-1:0] in_DestRob,
  input  logic [31:0]        in_CurPC,
  input  logic               cdb_ready,
  output logic               out_valid,
  output logic [ROB_LOG-1:0] out_RobId,
  output logic [31:0]        out_value,
  output logic               out_jump,
  output logic [31:0]        out_target,
  output logic               fu_next_full
);
  localparam int PW = $clog2(QDEPTH);
  localparam int NS = (MUL_STAGES > 1) ? MUL_STAGES - 1 : 1;

  typedef struct packed {
    logic [ROB_LOG-1:0] rob;
    logic [31:0]        value;
    logic               jump;
    logic [31:0]        target;
  } ent_t;

  logic          accept, is_mul, mul_req, alu_req, pop;
  logic [31:0]   pc4, br_tgt, jalr_tgt;
  ent_t          alu_ent, mul_ent, e0;
  ent_t          q [QDEPTH];
  logic [PW-1:0] head, tail;
  logic [PW:0]   count;
  int            inflight, free_i, req_i, push_i;

  assign accept   = in_valid & rdy & ~flush;
  assign pc4      = in_CurPC + 32'd4;
  assign br_tgt   = in_CurPC + in_Imm;
  assign jalr_tgt = (in_Vj + in_Imm) & ~32'd1;

  always_comb begin
    alu_ent.rob    = in_DestRob;
    alu_ent.value  = '0;
    alu_ent.jump   = 1'b0;
    alu_ent.target = pc4;
    is_mul         = 1'b0;
    case (in_op)
      OP_ADD:   alu_ent.value = in_Vj + in_Vk;
      OP_SUB:   alu_ent.value = in_Vj - in_Vk;
      OP_AND:   alu_ent.value = in_Vj & in_Vk;
      OP_OR:    alu_ent.value = in_Vj | in_Vk;
      OP_XOR:   alu_ent.value = in_Vj ^ in_Vk;
      OP_SLL:   alu_ent.value = in_Vj << in_Vk[4:0];
      OP_SRL:   alu_ent.value = in_Vj >> in_Vk[4:0];
      OP_SRA:   alu_ent.value = $signed(in_Vj) >>> in_Vk[4:0];
      OP_SLT:   alu_ent.value = {31'b0, $signed(in_Vj) < $signed(in_Vk)};
      OP_SLTU:  alu_ent.value = {31'b0, in_Vj < in_Vk};
      OP_ADDI:  alu_ent.value = in_Vj + in_Imm;
      OP_ANDI:  alu_ent.value = in_Vj & in_Imm;
      OP_ORI:   alu_ent.value = in_Vj | in_Imm;
      OP_XORI:  alu_ent.value = in_Vj ^ in_Imm;
      OP_SLLI:  alu_ent.value = in_Vj << in_Imm[4:0];
      OP_SRLI:  alu_ent.value = in_Vj >> in_Imm[4:0];
      OP_SRAI:  alu_ent.value = $signed(in_Vj) >>> in_Imm[4:0];
      OP_SLTI:  alu_ent.value = {31'b0, $signed(in_Vj) < $signed(in_Imm)};
      OP_SLTIU: alu_ent.value = {31'b0, in_Vj < in_Imm};
      OP_LUI:   alu_ent.value = in_Imm;
      OP_AUIPC: alu_ent.value = br_tgt;
      OP_JAL, OP_JALR: begin
        alu_ent.value = pc4;
        alu_ent.jump  = 1'b1;
      end
      OP_BEQ:   alu_ent.jump = (in_Vj == in_Vk);
      OP_BNE:   alu_ent.jump = (in_Vj != in_Vk);
      OP_BLT:   alu_ent.jump = $signed(in_Vj) < $signed(in_Vk);
      OP_BGE:   alu_ent.jump = $signed(in_Vj) >= $signed(in_Vk);
      OP_BLTU:  alu_ent.jump = in_Vj < in_Vk;
      OP_BGEU:  alu_ent.jump = in_Vj >= in_Vk;
`ifdef ALU_MUL_EN
      OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU: is_mul = 1'b1;
`endif
      default: ;
    endcase
    // Every taken transfer except JALR targets PC-relative.
    if (alu_ent.jump)
      alu_ent.target = (in_op == OP_JALR) ? jalr_tgt : br_tgt;
  end

`ifdef ALU_MUL_EN
  logic               m_vld [NS];
  logic [ROB_LOG-1:0] m_rob [NS];
  logic [31:0]        m_val [NS];
  logic [31:0]        m_tgt [NS];
  logic [63:0]        ma, mb, mprod;
  logic               sa, sb;

  // Sign-extend to 64 bits; the low 64 product bits are exact for all four ops.
  assign sa    = ((in_op == OP_MULH) || (in_op == OP_MULHSU)) & in_Vj[31];
  assign sb    = (in_op == OP_MULH) & in_Vk[31];
  assign ma    = {{32{sa}}, in_Vj};
  assign mb    = {{32{sb}}, in_Vk};
  assign mprod = ma * mb;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NS; i++) m_vld[i] <= 1'b0;
    end else if (rdy) begin
      if (flush) begin
        for (int i = 0; i < NS; i++) m_vld[i] <= 1'b0;
      end else begin
        m_vld[0] <= accept & is_mul;
        m_rob[0] <= in_DestRob;
        m_val[0] <= (in_op == OP_MUL) ? mprod[31:0] : mprod[63:32];
        m_tgt[0] <= pc4;
        for (int i = 1; i < NS; i++) begin
          m_vld[i] <= m_vld[i-1];
          m_rob[i] <= m_rob[i-1];
          m_val[i] <= m_val[i-1];
          m_tgt[i] <= m_tgt[i-1];
        end
      end
    end
  end

  assign mul_req = rdy & ~flush & m_vld[NS-1];
  assign mul_ent = '{rob: m_rob[NS-1], value: m_val[NS-1], jump: 1'b0, target: m_tgt[NS-1]};

  always_comb begin
    inflight = 0;
    for (int i = 0; i < NS; i++) inflight += int'(m_vld[i]);
  end
`else
  assign mul_req = 1'b0;
  assign mul_ent = '0;
  always_comb inflight = 0;
`endif

  assign out_valid    = rdy & (count != '0);
  assign out_RobId    = q[head].rob;
  assign out_value    = q[head].value;
  assign out_jump     = q[head].jump;
  assign out_target   = q[head].target;
  assign fu_next_full = (int'(count) + inflight) >= (QDEPTH - 2);

  // Multiplier result is older than a same-edge ALU result, so it takes the first slot.
  always_comb begin
    pop     = out_valid & cdb_ready;
    alu_req = accept & ~is_mul;
    free_i  = QDEPTH - int'(count) + int'(pop);
    req_i   = int'(mul_req) + int'(alu_req);
    push_i  = (req_i < free_i) ? req_i : free_i;
    e0      = mul_req ? mul_ent : alu_ent;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy) begin
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push_i > 0) q[tail] <= e0;
`ifdef ALU_MUL_EN
        if (push_i > 1) q[tail + PW'(1)] <= alu_ent;
`endif
        tail  <= tail + PW'(push_i);
        if (pop) head <= head + PW'(1);
        count <= count + (PW+1)'(push_i) - (PW+1)'(pop);
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk)
    if (!rst && rdy && !flush && (req_i > free_i))
      $error("alu_exec_unit: push into full result queue, entry dropped");
`endif
endmodule
